// File: rtl/maze_cursor_if.sv
// maze_cursor_if: control, video and probe signals between the maze cursor and its neighbours
interface maze_cursor_if;
    logic       restart;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       right_x;
    logic       left_x;
    logic       up_y;
    logic       down_y;
    logic       path_in;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] status;
    logic       crash_pulse;
    logic       win_pulse;
    logic       graph_on;
    logic [2:0] graph_rgb;

    modport master (
        output restart, video_on, pix_x, pix_y, right_x, left_x, up_y, down_y, path_in,
        input  probe_x, probe_y, pos_x, pos_y, status, crash_pulse, win_pulse, graph_on, graph_rgb
    );

    modport slave (
        input  restart, video_on, pix_x, pix_y, right_x, left_x, up_y, down_y, path_in,
        output probe_x, probe_y, pos_x, pos_y, status, crash_pulse, win_pulse, graph_on, graph_rgb
    );
endinterface

// File: rtl/maze_cursor.sv
// maze_cursor: tick-paced sprite mover with four-point path probing, clamping, win/crash status and ring sprite render
module maze_cursor #(
    parameter int         H_RES     = 640,
    parameter int         V_RES     = 480,
    parameter int         TICK_DIV  = 900000,
    parameter int         SCALE     = 1,
    parameter int         STEP      = 1,
    parameter int         START_X   = 324,
    parameter int         START_Y   = 244,
    parameter int         GOAL_Y    = 405,
    parameter int         WALL_MODE = 0,
    parameter logic [2:0] RGB       = 3'b100
) (
    input logic         clk,
    input logic         reset,
    maze_cursor_if.slave bus
);
    localparam int SIZE = 8 * SCALE;
    localparam int SH   = $clog2(SCALE);
    localparam int CW   = $clog2(TICK_DIV);
    localparam logic signed [10:0] XMAX = 11'(H_RES - SIZE);
    localparam logic signed [10:0] YMAX = 11'(V_RES - SIZE);
    localparam logic [63:0] RING = 64'h3C66_C3DB_DBC3_663C;
    localparam logic [1:0] PLAY = 2'b00, CRASH = 2'b01, WIN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_DEC  = 3'd5
    } state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [9:0]       r_pos_x, r_pos_y, r_cand_x, r_cand_y, r_probe_x, r_probe_y;
    logic [1:0]       r_status;
    logic             r_ok, r_win_pulse, r_crash_pulse;
    logic             w_clr, w_tick, w_move, w_go, w_load, w_ok_nxt, w_commit, w_win, w_crash;
    logic signed [10:0] w_dx, w_dy, w_sx, w_sy;
    logic [9:0]       w_cx, w_cy, w_px, w_py;
    logic             w_in_box;
    logic [2:0]       w_row, w_col;
    logic [5:0]       w_idx;

    assign w_clr  = reset | bus.restart;
    assign w_tick = r_cnt == CW'(TICK_DIV - 1);
    assign w_go   = r_state == S_IDLE && w_tick;

    always_ff @(posedge clk)
        if (w_clr) r_cnt <= '0;
        else       r_cnt <= w_tick ? '0 : r_cnt + CW'(1);

    // Candidate is formed in signed arithmetic so a step off the left/top edge clamps to 0 instead of wrapping
    always_comb begin
        w_dx   = bus.right_x && !bus.left_x ? 11'(STEP) : bus.left_x && !bus.right_x ? -11'(STEP) : 11'sd0;
        w_dy   = bus.down_y && !bus.up_y ? 11'(STEP) : bus.up_y && !bus.down_y ? -11'(STEP) : 11'sd0;
        w_sx   = $signed({1'b0, r_pos_x}) + w_dx;
        w_sy   = $signed({1'b0, r_pos_y}) + w_dy;
        w_cx   = w_sx < 0 ? 10'd0 : w_sx > XMAX ? 10'(XMAX) : w_sx[9:0];
        w_cy   = w_sy < 0 ? 10'd0 : w_sy > YMAX ? 10'(YMAX) : w_sy[9:0];
        w_move = (w_dx != 11'sd0 || w_dy != 11'sd0) && r_status == PLAY;
    end

    always_ff @(posedge clk)
        r_state <= w_clr ? S_IDLE : w_next;

    always_comb
        w_next = r_state == S_IDLE ? (w_go && w_move ? S_P0 : S_IDLE) :
                 r_state == S_DEC  ? S_IDLE : state_t'(r_state + 3'd1);

    // Probe register is loaded with the corner of the state being entered
    always_comb begin
        w_load   = (w_go && w_move) || r_state == S_P0 || r_state == S_P1 || r_state == S_P2;
        w_px     = r_state == S_IDLE ? w_cx + 10'(3 * SCALE) :
                   r_state == S_P0 || r_state == S_P2 ? r_cand_x + 10'(6 * SCALE) : r_cand_x + 10'(3 * SCALE);
        w_py     = r_state == S_IDLE ? w_cy : r_state == S_P0 ? r_cand_y : r_cand_y + 10'(SIZE);
        w_ok_nxt = r_state == S_IDLE ? 1'b1 : r_state == S_DEC ? r_ok : r_ok & bus.path_in;
        w_commit = r_state == S_DEC && r_ok;
        w_win    = w_commit && ({1'b0, r_cand_y} + 11'(SIZE) >= 11'(GOAL_Y));
        w_crash  = r_state == S_DEC && !r_ok && WALL_MODE == 1;
    end

    always_ff @(posedge clk)
        if (w_clr) begin
            r_pos_x       <= 10'(START_X);
            r_pos_y       <= 10'(START_Y);
            r_status      <= PLAY;
            r_cand_x      <= '0;
            r_cand_y      <= '0;
            r_probe_x     <= '0;
            r_probe_y     <= '0;
            r_ok          <= 1'b1;
            r_win_pulse   <= 1'b0;
            r_crash_pulse <= 1'b0;
        end else begin
            r_ok          <= w_ok_nxt;
            r_win_pulse   <= w_win;
            r_crash_pulse <= w_crash;
            if (w_go) begin
                r_cand_x <= w_cx;
                r_cand_y <= w_cy;
            end
            if (w_load) begin
                r_probe_x <= w_px;
                r_probe_y <= w_py;
            end
            if (w_commit) begin
                r_pos_x <= r_cand_x;
                r_pos_y <= r_cand_y;
            end
            if (w_win)   r_status <= WIN;
            if (w_crash) r_status <= CRASH;
        end

    always_comb begin
        w_in_box = bus.pix_x >= r_pos_x && {1'b0, bus.pix_x} < {1'b0, r_pos_x} + 11'(SIZE) &&
                   bus.pix_y >= r_pos_y && {1'b0, bus.pix_y} < {1'b0, r_pos_y} + 11'(SIZE);
        w_row    = 3'((bus.pix_y - r_pos_y) >> SH);
        w_col    = 3'((bus.pix_x - r_pos_x) >> SH);
        w_idx    = {w_row, w_col};
        bus.graph_on  = w_in_box && RING[~w_idx] && bus.video_on;
        bus.graph_rgb = bus.graph_on ? RGB : 3'b000;
    end

    assign bus.probe_x     = r_probe_x;
    assign bus.probe_y     = r_probe_y;
    assign bus.pos_x       = r_pos_x;
    assign bus.pos_y       = r_pos_y;
    assign bus.status      = r_status;
    assign bus.crash_pulse = r_crash_pulse;
    assign bus.win_pulse   = r_win_pulse;
endmodule
